alu_writeback: RTL

- Stage directly downstream of the ALU.
- Captures the ALU result and NZCV flags, evaluates the ARM condition field against the committed CPSR flags, and updates those flags when S is set.
- Queues register-file writes through a 2-entry skid buffer with a valid/ready handshake.
- Redirects the fetch stage on PC writes and feeds the committed C flag back to the ALU carry-in.

---
 rtl/alu_writeback_pkg.sv | 33 +++
 rtl/alu_writeback_cond_check.sv | 41 ++++
 rtl/alu_writeback.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/alu_writeback_pkg.sv
// Shared definitions for the ALU writeback stage: condition codes, flag bit
// positions and default widths.
package alu_writeback_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 4;
  localparam int PC_IDX     = 15;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,
    COND_NE = 4'd1,
    COND_CS = 4'd2,
    COND_CC = 4'd3,
    COND_MI = 4'd4,
    COND_PL = 4'd5,
    COND_VS = 4'd6,
    COND_VC = 4'd7,
    COND_HI = 4'd8,
    COND_LS = 4'd9,
    COND_GE = 4'd10,
    COND_LT = 4'd11,
    COND_GT = 4'd12,
    COND_LE = 4'd13,
    COND_AL = 4'd14,
    COND_NV = 4'd15
  } cond_e;

endpackage

// File: rtl/alu_writeback_cond_check.sv
// ARM condition-field evaluator: cond + {N,Z,C,V} -> pass. Purely combinational
// so the decode stage can reuse it.
module cond_check
  import alu_writeback_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    // NOTE: default assignment first so every path drives pass and no latch is inferred.
    pass = 1'b0;
    case (cond_e'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: condition evaluation, CPSR flag commit, 2-entry skid
// buffer for register writes and PC-write redirect. Optional ALU_WB_STATS_EN
// adds executed/skipped instruction counters.
module alu_writeback #(
  parameter int DATA_W = alu_writeback_pkg::DATA_W_DEF,
  parameter int REG_AW = alu_writeback_pkg::REG_AW_DEF,
  parameter int PC_IDX = alu_writeback_pkg::PC_IDX
) (
  input  logic              CP,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_n,
  input  logic              in_z,
  input  logic              in_c,
  input  logic              in_v,
  input  logic [3:0]        in_cond,
  input  logic              in_s,
  input  logic              in_we,
  input  logic [REG_AW-1:0] in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_AW-1:0] out_rd,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        flags,
  output logic              alu_cin,
  output logic              br_valid,
  output logic [DATA_W-1:0] br_target
`ifdef ALU_WB_STATS_EN
  ,
  output logic [31:0]       stat_exec,
  output logic [31:0]       stat_skip
`endif
);

  logic              pass;
  logic              accept;
  logic              exec;
  logic              is_pc;
  logic              push;
  logic              pop;
  logic              do_branch;

  logic              head_v, skid_v;
  logic [REG_AW-1:0] head_rd, skid_rd;
  logic [DATA_W-1:0] head_data, skid_data;

  cond_check u_cond_check (
    .cond  (in_cond),
    .flags (flags),
    .pass  (pass)
  );

  assign accept    = in_valid && in_ready;
  assign exec      = accept && pass;
  assign is_pc     = (in_rd == REG_AW'(PC_IDX));
  assign push      = exec && in_we && !is_pc;
  assign do_branch = exec && in_we && is_pc;
  assign pop       = head_v && out_ready;

  // Backpressure comes from occupancy alone, keeping out_ready off the upstream path.
  assign in_ready  = !skid_v;
  assign out_valid = head_v;
  assign out_rd    = head_rd;
  assign out_data  = head_data;
  assign alu_cin   = flags[alu_writeback_pkg::FLAG_C];

  always_ff @(posedge CP or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      flags <= 4'b0000;
    end else if (exec && in_s) begin
      flags <= {in_n, in_z, in_c, in_v};
    end
  end

  // Buffer storage is reset too: out_rd/out_data must read zero out of reset.
  always_ff @(posedge CP or negedge reset) begin
    if (!reset) begin
      head_v    <= 1'b0;
      skid_v    <= 1'b0;
      head_rd   <= '0;
      head_data <= '0;
      skid_rd   <= '0;
      skid_data <= '0;
    end else begin
      if (push && pop) begin
        if (skid_v) begin
          head_rd   <= skid_rd;
          head_data <= skid_data;
          skid_rd   <= in_rd;
          skid_data <= in_result;
        end else begin
          head_rd   <= in_rd;
          head_data <= in_result;
        end
      end else if (push) begin
        if (!head_v) begin
          head_v    <= 1'b1;
          head_rd   <= in_rd;
          head_data <= in_result;
        end else begin
          skid_v    <= 1'b1;
          skid_rd   <= in_rd;
          skid_data <= in_result;
        end
      end else if (pop) begin
        if (skid_v) begin
          head_rd   <= skid_rd;
          head_data <= skid_data;
          skid_v    <= 1'b0;
        end else begin
          head_v    <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CP or negedge reset) begin
    if (!reset) begin
      br_valid  <= 1'b0;
      br_target <= '0;
    end else begin
      br_valid <= do_branch;
      if (do_branch) begin
        br_target <= {in_result[DATA_W-1:2], 2'b00};
      end
    end
  end

`ifdef ALU_WB_STATS_EN
  always_ff @(posedge CP or negedge reset) begin
    if (!reset) begin
      stat_exec <= '0;
      stat_skip <= '0;
    end else if (accept) begin
      if (pass) begin
        stat_exec <= stat_exec + 32'd1;
      end else begin
        stat_skip <= stat_skip + 32'd1;
      end
    end
  end
`endif

endmodule
